// File: rtl/ece571_cpu_pkg.sv
// rtl/ece571_cpu_pkg.sv - shared CPU types: opcodes, instruction word, forwarding select
//
// Purpose: types shared by the ALU, the execute pipe and its interface.
//   opcode_t   ALU operation code
//   instr_t    {op, rd, rs1, rs2}
//   fwd_sel_t  operand source chosen at issue
//   forward_sel() priority resolver for one source operand

package ece571_cpu_pkg;

   localparam int CPU_N    = 32;
   localparam int CPU_NREG = 8;
   localparam int CPU_RW   = $clog2(CPU_NREG);

   typedef logic [CPU_RW-1:0] ridx_t;

   // Encodings 5..7 are undefined and make the ALU return 0.
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } opcode_t;

   typedef struct packed {
      opcode_t op;
      ridx_t   rd;
      ridx_t   rs1;
      ridx_t   rs2;
   } instr_t;

   typedef enum logic [1:0] {
      FWD_ZERO = 2'd0,
      FWD_E    = 2'd1,
      FWD_W    = 2'd2,
      FWD_RF   = 2'd3
   } fwd_sel_t;

   // Youngest producer wins: the E stage holds a newer result than W,
   // and W is newer than the register file.
   function automatic fwd_sel_t forward_sel(input ridx_t idx,
                                            input logic  e_valid,
                                            input ridx_t e_rd,
                                            input logic  w_valid,
                                            input ridx_t w_rd);
      if (idx == '0)
         return FWD_ZERO;
      if (e_valid && (e_rd == idx))
         return FWD_E;
      if (w_valid && (w_rd == idx))
         return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/ece571_exec_pipe_if.sv
// rtl/ece571_exec_pipe_if.sv - issue, host-init, ALU and writeback signals of the execute pipe
//
// Purpose: bundles every non-clock signal of ece571_exec_pipe.
//   slave  modport: the pipe itself
//   master modport: the surrounding decode/host/ALU side
// Signals:
//   in_valid/in_ready/in_instr     instruction handshake
//   init_we/init_addr/init_data    host register-file preload
//   alu_opcode/alu_a/alu_b         registered E stage to the ALU
//   alu_result                     combinational ALU result
//   wb_valid/wb_rd/wb_data         registered W stage

interface ece571_exec_pipe_if
   import ece571_cpu_pkg::*;
#(
   parameter int N    = CPU_N,
   parameter int NREG = CPU_NREG
) ();

   localparam int RW = $clog2(NREG);

   logic          in_valid;
   logic          in_ready;
   instr_t        in_instr;
   logic          init_we;
   logic [RW-1:0] init_addr;
   logic [N-1:0]  init_data;
   opcode_t       alu_opcode;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [N-1:0]  alu_result;
   logic          wb_valid;
   logic [RW-1:0] wb_rd;
   logic [N-1:0]  wb_data;

   modport slave (
      input  in_valid, in_instr, init_we, init_addr, init_data, alu_result,
      output in_ready, alu_opcode, alu_a, alu_b, wb_valid, wb_rd, wb_data
   );

   modport master (
      output in_valid, in_instr, init_we, init_addr, init_data, alu_result,
      input  in_ready, alu_opcode, alu_a, alu_b, wb_valid, wb_rd, wb_data
   );

endinterface

// File: rtl/ece571_alu.sv
// rtl/ece571_alu.sv - combinational ALU, modulo 2^N, undefined opcodes give 0
//
// Ports:
//   opcode  in  opcode_t  operation
//   a, b    in  N         operands
//   result  out N         combinational result

module ece571_alu
   import ece571_cpu_pkg::*;
#(
   parameter int N = CPU_N
) (
   input  opcode_t      opcode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result
);

   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ece571_regfile.sv
// rtl/ece571_regfile.sv - NREG x N register file, two async reads, one prioritised write
//
// Ports:
//   clk, reset                  clock, synchronous active-high clear of all registers
//   raddr1/rdata1, raddr2/rdata2 asynchronous read ports (r0 reads 0)
//   w_en/w_addr/w_data          pipeline writeback
//   init_we/init_addr/init_data host preload; dropped when it targets the writeback register

module ece571_regfile #(
   parameter int N    = 32,
   parameter int NREG = 8,
   parameter int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] raddr1,
   output logic [N-1:0]  rdata1,
   input  logic [RW-1:0] raddr2,
   output logic [N-1:0]  rdata2,
   input  logic          w_en,
   input  logic [RW-1:0] w_addr,
   input  logic [N-1:0]  w_data,
   input  logic          init_we,
   input  logic [RW-1:0] init_addr,
   input  logic [N-1:0]  init_data
);

   logic [N-1:0] regs [NREG];
   logic         init_ok;

   // Writeback has priority over a host write to the same register.
   assign init_ok = init_we && (init_addr != '0) && !(w_en && (w_addr == init_addr));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         if (init_ok)
            regs[init_addr] <= init_data;
         if (w_en && (w_addr != '0))
            regs[w_addr] <= w_data;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ece571_exec_pipe.sv
// rtl/ece571_exec_pipe.sv - operand issue, E/W pipeline registers and writeback around the ALU
//
// Ports:
//   clk    clock; all state updates on posedge
//   reset  synchronous, active-high; clears E/W and the register file
//   bus    ece571_exec_pipe_if.slave: instruction handshake, host preload,
//          E-stage ALU drive, ALU result, W-stage writeback

module ece571_exec_pipe
   import ece571_cpu_pkg::*;
#(
   parameter int N    = CPU_N,
   parameter int NREG = CPU_NREG
) (
   input logic                clk,
   input logic                reset,
   ece571_exec_pipe_if.slave  bus
);

   localparam int RW = $clog2(NREG);

   logic          xfer;
   instr_t        instr;
   logic [N-1:0]  rf_a;
   logic [N-1:0]  rf_b;
   logic [N-1:0]  opnd_a;
   logic [N-1:0]  opnd_b;

   logic          e_valid;
   logic [RW-1:0] e_rd;
   opcode_t       e_op;
   logic [N-1:0]  e_a;
   logic [N-1:0]  e_b;

   logic          w_valid;
   logic [RW-1:0] w_rd;
   logic [N-1:0]  w_data;

   // A host write owns the cycle; no other stall source exists.
   assign bus.in_ready = !reset && !bus.init_we;
   assign xfer         = bus.in_valid && bus.in_ready;
   assign instr        = bus.in_instr;

   ece571_regfile #(.N(N), .NREG(NREG), .RW(RW)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .raddr1    (instr.rs1),
      .rdata1    (rf_a),
      .raddr2    (instr.rs2),
      .rdata2    (rf_b),
      .w_en      (w_valid),
      .w_addr    (w_rd),
      .w_data    (w_data),
      .init_we   (bus.init_we),
      .init_addr (bus.init_addr),
      .init_data (bus.init_data)
   );

   function automatic logic [N-1:0] pick(input fwd_sel_t     sel,
                                         input logic [N-1:0] e_fwd,
                                         input logic [N-1:0] w_fwd,
                                         input logic [N-1:0] rf);
      case (sel)
         FWD_E:   return e_fwd;
         FWD_W:   return w_fwd;
         FWD_RF:  return rf;
         default: return '0;
      endcase
   endfunction

   // The E-stage forward is the live ALU output, so a dependent instruction
   // issued right behind its producer never stalls.
   always_comb begin
      opnd_a = pick(forward_sel(instr.rs1, e_valid, e_rd, w_valid, w_rd),
                    bus.alu_result, w_data, rf_a);
      opnd_b = pick(forward_sel(instr.rs2, e_valid, e_rd, w_valid, w_rd),
                    bus.alu_result, w_data, rf_b);
   end

   // E payload only moves on a transfer so the ALU inputs hold through bubbles;
   // W payload likewise holds when E was empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid <= 1'b0;
         e_rd    <= '0;
         e_op    <= OP_ADD;
         e_a     <= '0;
         e_b     <= '0;
         w_valid <= 1'b0;
         w_rd    <= '0;
         w_data  <= '0;
      end else begin
         e_valid <= xfer;
         if (xfer) begin
            e_rd <= instr.rd;
            e_op <= instr.op;
            e_a  <= opnd_a;
            e_b  <= opnd_b;
         end
         w_valid <= e_valid;
         if (e_valid) begin
            w_rd   <= e_rd;
            w_data <= bus.alu_result;
         end
      end
   end

   assign bus.alu_opcode = e_op;
   assign bus.alu_a      = e_a;
   assign bus.alu_b      = e_b;
   assign bus.wb_valid   = w_valid;
   assign bus.wb_rd      = w_rd;
   assign bus.wb_data    = w_data;

endmodule

// File: tb/tb_ece571_exec_pipe.sv
// tb/tb_ece571_exec_pipe.sv - directed self-checking bench for ece571_exec_pipe with ece571_alu

module tb_ece571_exec_pipe;
   import ece571_cpu_pkg::*;

   localparam int N    = 32;
   localparam int NREG = 8;

   logic clk = 1'b0;
   logic reset;

   int errors = 0;
   int checks = 0;

   ece571_exec_pipe_if #(.N(N), .NREG(NREG)) pif ();

   ece571_exec_pipe #(.N(N), .NREG(NREG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (pif.slave)
   );

   ece571_alu #(.N(N)) alu (
      .opcode (pif.alu_opcode),
      .a      (pif.alu_a),
      .b      (pif.alu_b),
      .result (pif.alu_result)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic instr_t mk(input opcode_t op, input int rd, input int rs1, input int rs2);
      instr_t t;
      t.op  = op;
      t.rd  = ridx_t'(rd);
      t.rs1 = ridx_t'(rs1);
      t.rs2 = ridx_t'(rs2);
      return t;
   endfunction

   task automatic host_init(input int addr, input logic [31:0] data);
      pif.init_we   = 1'b1;
      pif.init_addr = 3'(addr);
      pif.init_data = data;
      #1;
      chk("init_blocks_ready", {63'd0, pif.in_ready}, 64'd0);
      tick();
      pif.init_we = 1'b0;
   endtask

   // Reads a register by issuing ADD r0,idx,r0 into an empty pipe and
   // watching the writeback value two cycles later.
   task automatic read_reg(input string tag, input int idx, input logic [31:0] expv);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 0, idx, 0);
      tick();
      pif.in_valid = 1'b0;
      tick();
      chk({tag, "_valid"}, {63'd0, pif.wb_valid}, 64'd1);
      chk(tag, {32'd0, pif.wb_data}, {32'd0, expv});
   endtask

   initial begin
      reset         = 1'b1;
      pif.in_valid  = 1'b0;
      pif.in_instr  = mk(OP_ADD, 0, 0, 0);
      pif.init_we   = 1'b0;
      pif.init_addr = '0;
      pif.init_data = '0;

      // 1. reset, preload, simple ADD
      tick();
      tick();
      chk("rst_in_ready",   {63'd0, pif.in_ready},   64'd0);
      chk("rst_wb_valid",   {63'd0, pif.wb_valid},   64'd0);
      chk("rst_alu_opcode", {61'd0, pif.alu_opcode}, {61'd0, OP_ADD});
      chk("rst_alu_a",      {32'd0, pif.alu_a},      64'd0);
      chk("rst_wb_data",    {32'd0, pif.wb_data},    64'd0);
      reset = 1'b0;
      host_init(1, 32'd5);
      host_init(2, 32'd3);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 3, 1, 2);
      #1;
      chk("t1_in_ready", {63'd0, pif.in_ready}, 64'd1);
      tick();
      pif.in_valid = 1'b0;
      chk("t1_e_stage_no_wb", {63'd0, pif.wb_valid}, 64'd0);
      tick();
      chk("t1_wb_valid", {63'd0, pif.wb_valid}, 64'd1);
      chk("t1_wb_rd",    {61'd0, pif.wb_rd},    64'd3);
      chk("t1_wb_data",  {32'd0, pif.wb_data},  64'd8);
      chk("t1_alu_a_hold", {32'd0, pif.alu_a},  64'd5);
      tick();
      chk("t1_wb_done", {63'd0, pif.wb_valid}, 64'd0);

      // 2. back-to-back dependency through E forward
      host_init(3, 32'd0);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 3, 1, 2);
      tick();
      pif.in_instr = mk(OP_SUB, 4, 3, 1);
      #1;
      chk("t2_no_stall", {63'd0, pif.in_ready}, 64'd1);
      tick();
      pif.in_valid = 1'b0;
      chk("t2_add_wb_data", {32'd0, pif.wb_data}, 64'd8);
      tick();
      chk("t2_sub_wb_valid", {63'd0, pif.wb_valid}, 64'd1);
      chk("t2_sub_wb_rd",    {61'd0, pif.wb_rd},    64'd4);
      chk("t2_sub_wb_data",  {32'd0, pif.wb_data},  64'd3);
      tick();

      // 3. one bubble, dependency through W forward
      host_init(3, 32'd0);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 3, 1, 2);
      tick();
      pif.in_valid = 1'b0;
      tick();
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_XOR, 5, 3, 2);
      tick();
      pif.in_valid = 1'b0;
      tick();
      chk("t3_xor_wb_rd",   {61'd0, pif.wb_rd},   64'd5);
      chk("t3_xor_wb_data", {32'd0, pif.wb_data}, 64'd11);
      tick();
      tick();
      read_reg("t3_r5", 5, 32'd11);
      tick();
      tick();

      // 4. wrap-around and r0 hardwired zero
      host_init(6, 32'hFFFF_FFFF);
      host_init(7, 32'd1);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 6, 6, 7);
      tick();
      pif.in_valid = 1'b0;
      tick();
      chk("t4_wrap_rd",   {61'd0, pif.wb_rd},   64'd6);
      chk("t4_wrap_data", {32'd0, pif.wb_data}, 64'd0);
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 0, 7, 7);
      tick();
      pif.in_valid = 1'b0;
      tick();
      chk("t4_r0_wb_valid", {63'd0, pif.wb_valid}, 64'd1);
      chk("t4_r0_wb_rd",    {61'd0, pif.wb_rd},    64'd0);
      chk("t4_r0_wb_data",  {32'd0, pif.wb_data},  64'd2);
      tick();
      tick();
      read_reg("t4_r0_zero", 0, 32'd0);
      tick();
      tick();
      read_reg("t4_r6", 6, 32'd0);
      tick();
      tick();

      // 5. host write blocks issue; writeback beats a colliding host write
      pif.in_valid  = 1'b1;
      pif.in_instr  = mk(OP_ADD, 5, 1, 2);
      pif.init_we   = 1'b1;
      pif.init_addr = 3'd7;
      pif.init_data = 32'd9;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t5_blocked_ready", {63'd0, pif.in_ready}, 64'd0);
         tick();
         chk("t5_blocked_no_wb", {63'd0, pif.wb_valid}, 64'd0);
      end
      pif.init_we = 1'b0;
      #1;
      chk("t5_ready_after_init", {63'd0, pif.in_ready}, 64'd1);
      tick();
      pif.in_valid = 1'b0;
      tick();
      chk("t5_wb_valid", {63'd0, pif.wb_valid}, 64'd1);
      chk("t5_wb_rd",    {61'd0, pif.wb_rd},    64'd5);
      chk("t5_wb_data",  {32'd0, pif.wb_data},  64'd8);
      pif.init_we   = 1'b1;
      pif.init_addr = 3'd5;
      pif.init_data = 32'd77;
      tick();
      pif.init_we = 1'b0;
      chk("t5_single_accept", {63'd0, pif.wb_valid}, 64'd0);
      tick();
      read_reg("t5_r5_wb_wins", 5, 32'd8);
      tick();
      tick();
      read_reg("t5_r7_init", 7, 32'd9);
      tick();
      tick();

      // 6. reset right after an accept discards the instruction
      pif.in_valid = 1'b1;
      pif.in_instr = mk(OP_ADD, 3, 1, 2);
      tick();
      pif.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_rst_in_ready", {63'd0, pif.in_ready}, 64'd0);
      tick();
      chk("t6_no_wb_0", {63'd0, pif.wb_valid}, 64'd0);
      reset = 1'b0;
      tick();
      chk("t6_no_wb_1", {63'd0, pif.wb_valid}, 64'd0);
      tick();
      chk("t6_no_wb_2", {63'd0, pif.wb_valid}, 64'd0);
      read_reg("t6_r1", 1, 32'd0);
      tick();
      tick();
      read_reg("t6_r3", 3, 32'd0);
      tick();
      tick();
      read_reg("t6_r7", 7, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
